// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT
   } tx_pace_state_t;

   // Clocks per frame: 10 bits (start, 8 data, stop) of two half-bits each, plus idle guard.
   function automatic logic [31:0] frame_clks(input int unsigned half_bit, input int unsigned guard);
      return 32'(20 * half_bit + guard);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is presented combinationally.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // A full FIFO refuses writes even if a pop happens in the same cycle.
   assign full    = (count == (AW+1)'(DEPTH));
   assign wr_acc  = wr_en && !full;
   assign rd_acc  = pop && (count != '0);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks net push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus frame pacer feeding a UART transmitter with a one-cycle start strobe.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int CLK_PER_HALF_BIT = 5208,
   parameter  int DEPTH            = 16,
   parameter  int GUARD_CLKS       = 4,
   localparam int CW               = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_en,
   output logic                   full,
   output logic [CW-1:0]          count,
   output logic                   overflow,
   input  logic                   ovf_clr,
   output logic                   tx_idle,
   output logic [UART_DATA_W-1:0] sdata,
   output logic                   tx_start
);

   // The transmitter gives no frame-long busy, so the pacer times each frame itself.
   localparam logic [31:0] FRAME_CLKS = frame_clks(CLK_PER_HALF_BIT, GUARD_CLKS);

   tx_pace_state_t         state;
   logic [31:0]            frame_cnt;
   logic [UART_DATA_W-1:0] head;
   logic                   pop;

   assign pop     = (state == S_IDLE) && (count != '0);
   assign tx_idle = (state == S_IDLE) && (count == '0);

   sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .pop     (pop),
      .rd_data (head),
      .count   (count),
      .full    (full)
   );

   // Pacing FSM: pop and strobe low for one cycle, then hold off for the rest of the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         frame_cnt <= '0;
         sdata     <= '0;
         tx_start  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  sdata     <= head;
                  tx_start  <= 1'b0;
                  frame_cnt <= FRAME_CLKS - 32'd1;
                  state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               tx_start  <= 1'b1;
               frame_cnt <= frame_cnt - 32'd1;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (frame_cnt == '0) state <= S_IDLE;
               else                 frame_cnt <= frame_cnt - 32'd1;
            end
            default: begin
               tx_start <= 1'b1;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky overflow; a dropped write in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (rst)                 overflow <= 1'b0;
      else if (wr_en && full)  overflow <= 1'b1;
      else if (ovf_clr)        overflow <= 1'b0;
   end

endmodule
